// File: rtl/iob_pw_fifo.sv
// Posted-write FIFO between the FSB and the IOB master: buffers accepted writes
// and replays them in order through a four-state request/ack handshake.
module iob_pw_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 23,
    parameter int DW    = 16
) (
    input  logic                       CLK,
    input  logic                       nRES,
    input  logic                       WrEn,
    input  logic [AW-1:0]              WrA,
    input  logic [DW-1:0]              WrD,
    input  logic                       WrL,
    input  logic                       WrU,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       IOWRREQ,
    output logic [AW-1:0]              IOA,
    output logic [DW-1:0]              IOD,
    output logic                       IOL,
    output logic                       IOU,
    input  logic                       IOACT,
    input  logic                       IODONE,
    input  logic                       IOBERR,
    input  logic                       Drain,
    output logic                       Drained,
    output logic                       ErrSticky,
    output logic                       OvfSticky,
    input  logic                       ErrClr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW + 2;

    localparam logic [PW:0]   PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACT   = 2'd2,
        ST_RECOV = 2'd3
    } state_t;

    state_t          state_q, state_d;
    // Pointers carry one extra wrap bit so tail-head yields 0..DEPTH directly.
    logic [PW:0]     head_q, head_d;
    logic [PW:0]     tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            iowrreq_q, iowrreq_d;
    logic            drained_q, drained_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head_entry_s;

    logic            push_s;
    logic            pop_s;
    logic            ovf_set_s;
    logic            err_set_s;
    logic            drain_unused_s;

    // Drain never gates pushes; the requester combines it with Drained itself.
    assign drain_unused_s = Drain;

    assign push_s    = WrEn & ~full_q;
    assign ovf_set_s = WrEn & full_q;
    assign err_set_s = pop_s & IOBERR;

    // Master handshake next-state decode; the pop is tied to IODONE in ACT.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !IOACT) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (IOACT) begin
                    state_d = ST_ACT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACT: begin
                if (IODONE) begin
                    state_d = ST_RECOV;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_ACT;
                end
            end
            ST_RECOV: begin
                if (!IOACT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOV;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pop_s   = 1'b0;
            end
        endcase
    end

    // Pointer advance and derived occupancy flags.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        count_d   = tail_d - head_d;
        empty_d   = (count_d == CNT_ZERO);
        full_d    = (count_d == CNT_FULL);
        iowrreq_d = (state_d == ST_REQ);
        drained_d = empty_d & (state_d == ST_IDLE) & ~IOACT;
    end

    // Sticky status: a set on the same edge outranks the clear.
    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (ErrClr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ErrClr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q   <= ST_IDLE;
            head_q    <= {(PW+1){1'b0}};
            tail_q    <= {(PW+1){1'b0}};
            count_q   <= CNT_ZERO;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            iowrreq_q <= 1'b0;
            drained_q <= 1'b1;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            iowrreq_q <= iowrreq_d;
            drained_q <= drained_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[tail_q[PW-1:0]] <= {WrA, WrD, WrL, WrU};
        end
    end

    assign head_entry_s = mem_q[head_q[PW-1:0]];

    assign IOA       = head_entry_s[EW-1 -: AW];
    assign IOD       = head_entry_s[DW+1 -: DW];
    assign IOL       = head_entry_s[1];
    assign IOU       = head_entry_s[0];
    assign Full      = full_q;
    assign Empty     = empty_q;
    assign Count     = count_q;
    assign IOWRREQ   = iowrreq_q;
    assign Drained   = drained_q;
    assign ErrSticky = err_q;
    assign OvfSticky = ovf_q;

endmodule

// File: tb/tb_iob_pw_fifo.sv
// Self-checking bench: directed cases on a DEPTH=4 instance, then a randomized
// master/writer run on a DEPTH=16 instance against a queue-based reference.
module tb_iob_pw_fifo;

    localparam int AW = 23;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nres;

    logic          wr4, wl4, wu4, act4, done4, berr4, drain4, clr4;
    logic [AW-1:0] wa4;
    logic [DW-1:0] wd4;
    logic          full4, empty4, req4, iol4, iou4, drained4, err4, ovf4;
    logic [2:0]    cnt4;
    logic [AW-1:0] ioa4;
    logic [DW-1:0] iod4;

    logic          wr16, wl16, wu16, act16, done16, berr16, drain16, clr16;
    logic [AW-1:0] wa16;
    logic [DW-1:0] wd16;
    logic          full16, empty16, req16, iol16, iou16, drained16, err16, ovf16;
    logic [4:0]    cnt16;
    logic [AW-1:0] ioa16;
    logic [DW-1:0] iod16;

    int n_chk = 0;
    int n_err = 0;

    ent_t mq[$];
    ent_t ne;
    int   phase, dly, acc, pops;
    logic m_err, m_ovf, exp_drained, do_pop, clr, full_before;

    iob_pw_fifo #(.DEPTH(4), .AW(AW), .DW(DW)) u_dut4 (
        .CLK(clk), .nRES(nres), .WrEn(wr4), .WrA(wa4), .WrD(wd4), .WrL(wl4), .WrU(wu4),
        .Full(full4), .Empty(empty4), .Count(cnt4), .IOWRREQ(req4),
        .IOA(ioa4), .IOD(iod4), .IOL(iol4), .IOU(iou4),
        .IOACT(act4), .IODONE(done4), .IOBERR(berr4), .Drain(drain4), .Drained(drained4),
        .ErrSticky(err4), .OvfSticky(ovf4), .ErrClr(clr4)
    );

    iob_pw_fifo #(.DEPTH(16), .AW(AW), .DW(DW)) u_dut16 (
        .CLK(clk), .nRES(nres), .WrEn(wr16), .WrA(wa16), .WrD(wd16), .WrL(wl16), .WrU(wu16),
        .Full(full16), .Empty(empty16), .Count(cnt16), .IOWRREQ(req16),
        .IOA(ioa16), .IOD(iod16), .IOL(iol16), .IOU(iou16),
        .IOACT(act16), .IODONE(done16), .IOBERR(berr16), .Drain(drain16), .Drained(drained16),
        .ErrSticky(err16), .OvfSticky(ovf16), .ErrClr(clr16)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l, input logic u);
        wr4 = 1'b1; wa4 = a; wd4 = d; wl4 = l; wu4 = u;
        @(negedge clk);
        wr4 = 1'b0;
    endtask

    // Wait for a request, check the presented head, then run one full handshake.
    task automatic serve4(input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic el,
                          input logic eu, input logic berr, input logic clr_in);
        int n;
        n = 0;
        while (!req4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("srv_req", 32'(req4), 32'd1);
        check_eq("srv_ioa", 32'(ioa4), 32'(ea));
        check_eq("srv_iod", 32'(iod4), 32'(ed));
        check_eq("srv_lu", 32'({iol4, iou4}), 32'({el, eu}));
        act4 = 1'b1;
        @(negedge clk);
        check_eq("srv_req_drop", 32'(req4), 32'd0);
        done4 = 1'b1; berr4 = berr; clr4 = clr_in;
        @(negedge clk);
        done4 = 1'b0; berr4 = 1'b0; clr4 = 1'b0; act4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        nres = 1'b0;
        wr4 = 1'b0; wl4 = 1'b0; wu4 = 1'b0; act4 = 1'b0; done4 = 1'b0; berr4 = 1'b0;
        drain4 = 1'b1; clr4 = 1'b0; wa4 = '0; wd4 = '0;
        wr16 = 1'b0; wl16 = 1'b0; wu16 = 1'b0; act16 = 1'b0; done16 = 1'b0; berr16 = 1'b0;
        drain16 = 1'b0; clr16 = 1'b0; wa16 = '0; wd16 = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_empty", 32'(empty4), 32'd1);
        check_eq("rst_full", 32'(full4), 32'd0);
        check_eq("rst_count", 32'(cnt4), 32'd0);
        check_eq("rst_req", 32'(req4), 32'd0);
        check_eq("rst_drained", 32'(drained4), 32'd1);
        check_eq("rst_stickies", 32'({err4, ovf4}), 32'd0);
        check_eq("rst_empty16", 32'(empty16), 32'd1);
        nres = 1'b1;
        @(negedge clk);

        // Single write: latency, presented fields, handshake, drained.
        push4(23'h580000, 16'hA55A, 1'b1, 1'b0);
        check_eq("lat_req_early", 32'(req4), 32'd0);
        check_eq("lat_count", 32'(cnt4), 32'd1);
        check_eq("lat_empty", 32'(empty4), 32'd0);
        @(negedge clk);
        check_eq("lat_req", 32'(req4), 32'd1);
        check_eq("lat_ioa", 32'(ioa4), 32'h580000);
        check_eq("lat_iod", 32'(iod4), 32'hA55A);
        check_eq("lat_lu", 32'({iol4, iou4}), 32'b10);
        act4 = 1'b1;
        @(negedge clk);
        check_eq("act_req", 32'(req4), 32'd0);
        check_eq("act_drained", 32'(drained4), 32'd0);
        done4 = 1'b1;
        @(negedge clk);
        done4 = 1'b0;
        check_eq("done_empty", 32'(empty4), 32'd1);
        check_eq("done_drained", 32'(drained4), 32'd0);
        act4 = 1'b0;
        @(negedge clk);
        check_eq("idle_drained", 32'(drained4), 32'd1);

        // Bus error sticky, clear, and set-beats-clear.
        push4(23'h000123, 16'h0BAD, 1'b0, 1'b1);
        serve4(23'h000123, 16'h0BAD, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("berr_sticky", 32'(err4), 32'd1);
        check_eq("berr_popped", 32'(empty4), 32'd1);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        check_eq("berr_clr", 32'(err4), 32'd0);
        push4(23'h000456, 16'h1234, 1'b1, 1'b1);
        serve4(23'h000456, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("berr_set_wins", 32'(err4), 32'd1);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;

        // Push on the same edge as a pop with two entries queued.
        push4(23'h111111, 16'h1111, 1'b1, 1'b0);
        push4(23'h222222, 16'h2222, 1'b0, 1'b1);
        check_eq("pp_req", 32'(req4), 32'd1);
        act4 = 1'b1;
        @(negedge clk);
        check_eq("pp_count_pre", 32'(cnt4), 32'd2);
        done4 = 1'b1; wr4 = 1'b1; wa4 = 23'h333333; wd4 = 16'h3333; wl4 = 1'b1; wu4 = 1'b1;
        @(negedge clk);
        done4 = 1'b0; wr4 = 1'b0;
        check_eq("pp_count", 32'(cnt4), 32'd2);
        check_eq("pp_head", 32'(ioa4), 32'h222222);
        act4 = 1'b0;
        @(negedge clk);
        serve4(23'h222222, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0);
        serve4(23'h333333, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("pp_empty", 32'(empty4), 32'd1);

        // Fill to Full, overflow drop, then async reset while in ACT.
        for (int i = 0; i < 4; i++) begin
            push4(23'h100000 + 23'(i), 16'h1000 + 16'(i), 1'(i % 2), 1'(i / 2));
        end
        check_eq("fill_full", 32'(full4), 32'd1);
        check_eq("fill_count", 32'(cnt4), 32'd4);
        push4(23'h7FFFFF, 16'hFFFF, 1'b1, 1'b1);
        check_eq("ovf_count", 32'(cnt4), 32'd4);
        check_eq("ovf_sticky", 32'(ovf4), 32'd1);
        check_eq("ovf_head", 32'(ioa4), 32'h100000);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        check_eq("ovf_clr", 32'(ovf4), 32'd0);
        act4 = 1'b1;
        @(negedge clk);
        done4 = 1'b1;
        @(negedge clk);
        done4 = 1'b0; act4 = 1'b0;
        check_eq("rr_count3", 32'(cnt4), 32'd3);
        check_eq("rr_notfull", 32'(full4), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rr_req", 32'(req4), 32'd1);
        check_eq("rr_head", 32'(ioa4), 32'h100001);
        act4 = 1'b1;
        @(negedge clk);
        check_eq("rr_act_count", 32'(cnt4), 32'd3);
        #2 nres = 1'b0;
        #1;
        check_eq("arst_count", 32'(cnt4), 32'd0);
        check_eq("arst_req", 32'(req4), 32'd0);
        check_eq("arst_drained", 32'(drained4), 32'd1);
        check_eq("arst_empty", 32'(empty4), 32'd1);
        act4 = 1'b0;
        @(negedge clk);
        nres = 1'b1;

        // Randomized run on the deep instance against a queue reference.
        phase = 0; dly = 0; acc = 0; pops = 0;
        m_err = 1'b0; m_ovf = 1'b0; exp_drained = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check_eq("r_count", 32'(cnt16), 32'(mq.size()));
            check_eq("r_empty", 32'(empty16), 32'(mq.size() == 0));
            check_eq("r_full", 32'(full16), 32'(mq.size() == 16));
            check_eq("r_ovf", 32'(ovf16), 32'(m_ovf));
            check_eq("r_err", 32'(err16), 32'(m_err));
            check_eq("r_drained", 32'(drained16), 32'(exp_drained));
            if (acc >= 40 && mq.size() == 0 && phase == 0) break;

            done16 = 1'b0; berr16 = 1'b0; do_pop = 1'b0;
            case (phase)
                0: begin
                    if (req16) begin
                        act16 = 1'b1; phase = 1; dly = $urandom_range(0, 3);
                    end else if ($urandom_range(0, 7) == 0) begin
                        done16 = 1'b1; berr16 = 1'b1;
                    end
                end
                1: begin
                    if (dly > 0) begin
                        dly--;
                    end else begin
                        check_eq("r_head_avail", 32'(mq.size() != 0), 32'd1);
                        if (mq.size() != 0) begin
                            check_eq("r_ioa", 32'(ioa16), 32'(mq[0].a));
                            check_eq("r_iod", 32'(iod16), 32'(mq[0].d));
                            check_eq("r_lu", 32'({iol16, iou16}), 32'({mq[0].l, mq[0].u}));
                            do_pop = 1'b1;
                        end
                        done16 = 1'b1; berr16 = ($urandom_range(0, 3) == 0);
                        phase = 2; dly = $urandom_range(0, 3);
                    end
                end
                default: begin
                    if (dly > 0) begin
                        dly--;
                        if ($urandom_range(0, 3) == 0) begin
                            done16 = 1'b1; berr16 = 1'b1;
                        end
                    end else begin
                        act16 = 1'b0; phase = 0;
                    end
                end
            endcase

            wr16 = (acc < 40) && ($urandom_range(0, 2) != 0);
            ne.a = 23'($urandom); ne.d = 16'($urandom);
            ne.l = 1'($urandom_range(0, 1)); ne.u = 1'($urandom_range(0, 1));
            wa16 = ne.a; wd16 = ne.d; wl16 = ne.l; wu16 = ne.u;
            clr = ($urandom_range(0, 15) == 0);
            clr16 = clr;

            full_before = (mq.size() == 16);
            if (do_pop) begin
                void'(mq.pop_front());
                pops++;
            end
            if (wr16 && !full_before) begin
                mq.push_back(ne);
                acc++;
            end
            if (do_pop && berr16) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            if (wr16 && full_before) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            exp_drained = (mq.size() == 0) && (phase == 0);
        end
        wr16 = 1'b0; done16 = 1'b0; act16 = 1'b0; clr16 = 1'b0;
        check_eq("r_accepted", 32'(acc), 32'd40);
        check_eq("r_popped", 32'(pops), 32'd40);
        check_eq("r_final_empty", 32'(empty16), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/iob_pw_fifo.md
IOB_PW_FIFO -- requirements
Module: iob_pw_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the posted-write entry count; legal range 2..16, power of two.
REQ-002 Parameter AW, default 23, SHALL set the width of the latched address (A[AW:1]).
REQ-003 Parameter DW, default 16, SHALL set the data width.
REQ-004 CLK  in  1  FSB clock; all state SHALL change on the rising edge.
REQ-005 nRES  in  1  reset; asynchronous, active-low.
REQ-006 WrEn  in  1  one-cycle pulse: accepted FSB posted write.
REQ-007 WrA  in  AW  write address. WrD  in  DW  write data. WrL, WrU  in  1 each  byte strobes (1 = lane active).
REQ-008 Full  out  1  no free entry. Empty  out  1  no valid entry. Count  out  clog2(DEPTH)+1  valid entries.
REQ-009 IOWRREQ  out  1  write request to the IOB master; IOA, IOD, IOL, IOU  out  AW/DW/1/1  head entry.
REQ-010 IOACT  in  1  master busy/acknowledge. IODONE  in  1  one-cycle completion pulse. IOBERR  in  1  bus error; valid with IODONE.
REQ-011 Drain  in  1  non-posted access pending. Drained  out  1  FIFO empty and master idle.
REQ-012 ErrSticky  out  1  posted write bus-errored. OvfSticky  out  1  write dropped while Full. ErrClr  in  1  clears both stickies.

Function
REQ-013 Storage SHALL be DEPTH entries of {A, D, L, U}, with wrapping head/tail pointers of clog2(DEPTH) bits.
REQ-014 Full, Empty, Count SHALL be registered; Count SHALL equal tail minus head plus wrap-bit correction, range 0..DEPTH.
REQ-015 WrEn with Full=0 SHALL write the entry at the tail and advance the tail by 1 in the same edge.
REQ-016 WrEn with Full=1 SHALL leave the FIFO unchanged and set OvfSticky, even if a pop occurs on the same edge.
REQ-017 A push and a pop on the same edge SHALL leave Count unchanged and SHALL advance both pointers.
REQ-018 Master FSM states: IDLE, REQ, ACT, RECOV.
REQ-019 IDLE -> REQ when Empty=0 and IOACT=0; IOWRREQ SHALL be 1 only in REQ.
REQ-020 REQ -> ACT on IOACT=1.
REQ-021 ACT -> RECOV on IODONE=1; the head entry SHALL pop on that edge.
REQ-022 RECOV -> IDLE when IOACT=0.
REQ-023 IOA/IOD/IOL/IOU SHALL show the head entry continuously and SHALL be stable from REQ entry until the pop.
REQ-024 IODONE with IOBERR=1 SHALL still pop the entry and set ErrSticky; there is no retry.
REQ-025 IODONE outside ACT SHALL be ignored.
REQ-026 ErrClr SHALL clear both stickies; a same-edge set SHALL win over ErrClr.
REQ-027 Drained SHALL be registered and equal Empty AND state==IDLE AND IOACT==0.
REQ-028 Drain=1 SHALL NOT block pushes; Drain only qualifies Drained.
REQ-029 Minimum latency from WrEn into an empty, idle FIFO to IOWRREQ=1 SHALL be 2 edges: push, then IDLE->REQ.
REQ-030 Back-to-back entries SHALL each pass through RECOV.

Reset
REQ-031 nRES=0 SHALL asynchronously clear both pointers and the FSM to IDLE, and set Empty=1, Full=0, Count=0, IOWRREQ=0, Drained=1, ErrSticky=0, OvfSticky=0.
REQ-032 Entry contents SHALL NOT be reset; the IOA/IOD outputs are don't-care while Empty=1.
REQ-033 Reset mid-transfer (REQ or ACT) SHALL discard all entries; no pop is recorded.

Verification
REQ-034 DEPTH=4: 4 WrEn pulses, IOACT held 0 -> Full=1, Count=4; 5th WrEn -> Count stays 4, OvfSticky=1.
REQ-035 Single write A=0x580000, D=0xA55A, L=1, U=0 into an empty FIFO -> IOWRREQ=1 two edges later with those values on IOA/IOD/IOL/IOU; IOACT=1 -> IOWRREQ=0; IODONE -> Empty=1; IOACT=0 -> Drained=1.
REQ-036 Count=2 with a push on the same edge as IODONE -> Count=2, head advances, new entry at the tail.
REQ-037 IODONE with IOBERR=1 -> entry popped, ErrSticky=1; ErrClr -> 0; ErrClr on the same edge as a new error -> ErrSticky=1.
REQ-038 nRES asserted while in ACT with Count=3 -> Count=0, IOWRREQ=0, Drained=1 immediately, not waiting for CLK.
REQ-039 DEPTH=16: 40 writes interleaved with random IOACT/IODONE timing -> IOB write order and data match the WrEn order exactly across pointer wrap.
